cam_pixel_capture: RTL and testbench

Upstream capture stage for the OV7670 camera path. Samples the camera's 8-bit parallel bus, qualified by VSYNC and HREF, and assembles byte pairs into 16-bit RGB565 pixels. Emits each pixel with a one-cycle valid strobe and a linear frame-buffer address. Feeds the pixel buffer / frame-buffer write port, and flags malformed lines and frames.

---
 rtl/cam_pixel_capture.sv | 122 ++++++++++++
 tb/tb_cam_pixel_capture.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_pixel_capture.sv
// OV7670 parallel-bus capture: pairs camera bytes into RGB565 pixels with a linear
// frame-buffer address, and flags malformed lines and over-long frames.
module cam_pixel_capture #(
    parameter int H_ACTIVE = 320,
    parameter int V_ACTIVE = 240,
    parameter int ADDR_W   = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              capture_en,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        cam_data,
    output logic [15:0]       pixel_out,
    output logic              pixel_valid,
    output logic [ADDR_W-1:0] pixel_addr,
    output logic              frame_done,
    output logic              line_err,
    output logic              ovf_err,
    output logic              busy
);
    // One extra bit so the counter can sit at H_ACTIVE*V_ACTIVE even when that equals 2^ADDR_W.
    localparam int CNT_W = ADDR_W + 1;
    localparam int X_W   = $clog2(H_ACTIVE + 2);
    localparam logic [CNT_W-1:0] PIX_TOTAL = CNT_W'(H_ACTIVE * V_ACTIVE);
    localparam logic [X_W-1:0]   X_FULL    = X_W'(H_ACTIVE);

    typedef enum logic [1:0] {IDLE, SYNC, ACTIVE} state_t;

    state_t           state, state_nxt;
    logic             vsync_q, href_q;
    logic             vsync_rise;
    logic             frame_start, frame_end;
    logic             phase;
    logic [7:0]       hi_byte;
    logic [CNT_W-1:0] addr_cnt;
    logic [X_W-1:0]   x_cnt;

    // Line length saturates one past H_ACTIVE so over-long lines never wrap back to a legal count.
    function automatic logic [X_W-1:0] sat_inc_x(input logic [X_W-1:0] x);
        return (x > X_FULL) ? x : x + 1'b1;
    endfunction

    assign vsync_rise  = vsync & ~vsync_q;
    assign frame_start = (state == SYNC) && !vsync;
    assign frame_end   = (state == ACTIVE) && vsync_rise;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (capture_en && vsync) state_nxt = SYNC;
            SYNC:    if (!vsync) state_nxt = ACTIVE;
            ACTIVE:  if (vsync_rise) state_nxt = capture_en ? SYNC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            phase       <= 1'b0;
            hi_byte     <= 8'd0;
            addr_cnt    <= '0;
            x_cnt       <= '0;
            pixel_out   <= 16'd0;
            pixel_valid <= 1'b0;
            pixel_addr  <= '0;
            frame_done  <= 1'b0;
            line_err    <= 1'b0;
            ovf_err     <= 1'b0;
        end else begin
            vsync_q     <= vsync;
            // href history only counts inside a frame, so a line already high at frame start is not a falling edge.
            href_q      <= href && (state == ACTIVE);
            pixel_valid <= 1'b0;
            frame_done  <= frame_end;
            if (frame_start) begin
                addr_cnt <= '0;
                x_cnt    <= '0;
                phase    <= 1'b0;
                line_err <= 1'b0;
                ovf_err  <= 1'b0;
            end else if (frame_end) begin
                phase <= 1'b0;
                x_cnt <= '0;
            end else if (state == ACTIVE) begin
                if (href) begin
                    if (!phase) begin
                        hi_byte <= cam_data;
                        phase   <= 1'b1;
                    end else begin
                        phase <= 1'b0;
                        x_cnt <= sat_inc_x(x_cnt);
                        if (addr_cnt == PIX_TOTAL) begin
                            ovf_err <= 1'b1;
                        end else begin
                            pixel_out   <= {hi_byte, cam_data};
                            pixel_valid <= 1'b1;
                            pixel_addr  <= addr_cnt[ADDR_W-1:0];
                            addr_cnt    <= addr_cnt + 1'b1;
                        end
                    end
                end else if (href_q) begin
                    if (phase || (x_cnt != X_FULL)) line_err <= 1'b1;
                    phase <= 1'b0;
                    x_cnt <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cam_pixel_capture.sv
// Scoreboard bench for cam_pixel_capture on a reduced 8x4 frame (32 pixels, 5-bit address).
module tb_cam_pixel_capture;
    localparam int H = 8;
    localparam int V = 4;
    localparam int AW = 5;
    localparam int TOTAL = H * V;

    logic          clk = 1'b0;
    logic          reset, capture_en, vsync, href;
    logic [7:0]    cam_data;
    logic [15:0]   pixel_out;
    logic          pixel_valid;
    logic [AW-1:0] pixel_addr;
    logic          frame_done, line_err, ovf_err, busy;

    cam_pixel_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .capture_en(capture_en), .vsync(vsync), .href(href),
        .cam_data(cam_data), .pixel_out(pixel_out), .pixel_valid(pixel_valid),
        .pixel_addr(pixel_addr), .frame_done(frame_done), .line_err(line_err),
        .ovf_err(ovf_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int fd_cnt = 0;
    int exp_addr = 0;
    logic [15+AW:0] exp_q[$];
    logic prev_valid = 1'b0;
    logic prev_fd = 1'b0;

    // Monitor: every strobe is popped against the scoreboard and must not follow another strobe.
    always @(negedge clk) begin
        logic [15+AW:0] e;
        if (pixel_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pixel got pix=%h addr=%0d want=no strobe", pixel_out, pixel_addr);
            end else begin
                e = exp_q.pop_front();
                if ({pixel_out, pixel_addr} !== e) begin
                    bad++;
                    $display("FAIL pixel got pix=%h addr=%0d want pix=%h addr=%0d",
                             pixel_out, pixel_addr, e[15+AW:AW], e[AW-1:0]);
                end
            end
            total++;
            if (prev_valid) begin
                bad++;
                $display("FAIL strobe_gap got back-to-back pixel_valid want single-cycle");
            end
        end
        if (frame_done) begin
            fd_cnt++;
            total++;
            if (prev_fd) begin
                bad++;
                $display("FAIL frame_done_width got 2+ cycles want 1");
            end
        end
        prev_valid = pixel_valid;
        prev_fd    = frame_done;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        href = 1'b1;
        cam_data = b;
        step();
    endtask

    task automatic send_pair(input logic [7:0] hi, input logic [7:0] lo, input bit push);
        send_byte(hi);
        if (push && exp_addr < TOTAL) begin
            exp_q.push_back({hi, lo, AW'(exp_addr)});
            exp_addr++;
        end
        send_byte(lo);
    endtask

    task automatic gap();
        href = 1'b0;
        repeat (3) step();
    endtask

    task automatic send_line(input int first_pix, input bit push);
        for (int i = 0; i < H; i++)
            send_pair(8'(first_pix + i + 8'h30), ~8'(first_pix + i), push);
        gap();
    endtask

    task automatic start_frame();
        href = 1'b0;
        vsync = 1'b1;
        step();
        step();
        vsync = 1'b0;
        step();
        exp_addr = 0;
    endtask

    initial begin
        reset = 1'b1; capture_en = 1'b0; vsync = 1'b0; href = 1'b0; cam_data = 8'd0;
        step();
        step();
        check("rst_pixel_out", 32'(pixel_out), 0);
        check("rst_pixel_valid", 32'(pixel_valid), 0);
        check("rst_pixel_addr", 32'(pixel_addr), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_line_err", 32'(line_err), 0);
        check("rst_ovf_err", 32'(ovf_err), 0);
        check("rst_busy", 32'(busy), 0);
        reset = 1'b0;
        step();

        // Full frame
        capture_en = 1'b1;
        start_frame();
        check("busy_active", 32'(busy), 1);
        for (int l = 0; l < V; l++) send_line(l * H, 1);
        check("full_last_addr", 32'(pixel_addr), TOTAL - 1);
        vsync = 1'b1;
        step();
        check("frame_done_pulse", 32'(frame_done), 1);
        step();
        check("frame_done_low", 32'(frame_done), 0);
        check("full_line_err", 32'(line_err), 0);
        check("full_ovf_err", 32'(ovf_err), 0);
        check("busy_sync", 32'(busy), 1);

        // RGB565 pairing, then a 17-byte line
        vsync = 1'b0;
        step();
        exp_addr = 0;
        send_pair(8'hF8, 8'h1F, 1);
        check("rgb_valid0", 32'(pixel_valid), 1);
        check("rgb_pix0", 32'(pixel_out), 32'hF81F);
        check("rgb_addr0", 32'(pixel_addr), 0);
        send_byte(8'h07);
        check("rgb_gap", 32'(pixel_valid), 0);
        if (exp_addr < TOTAL) begin
            exp_q.push_back({8'h07, 8'hE0, AW'(exp_addr)});
            exp_addr++;
        end
        send_byte(8'hE0);
        check("rgb_pix1", 32'(pixel_out), 32'h07E0);
        check("rgb_addr1", 32'(pixel_addr), 1);
        for (int i = 2; i < H; i++) send_pair(8'(i), 8'(i * 3), 1);
        gap();
        check("good_line_err", 32'(line_err), 0);
        for (int i = 0; i < H; i++) send_pair(8'(8'h40 + i), 8'(8'hC0 + i), 1);
        send_byte(8'hAA);
        check("odd_err_before", 32'(line_err), 0);
        href = 1'b0;
        step();
        check("odd_err_set", 32'(line_err), 1);
        check("odd_last_addr", 32'(pixel_addr), 15);
        repeat (2) step();
        vsync = 1'b1;
        step();
        step();
        check("odd_err_sticky", 32'(line_err), 1);

        // Frame with V+1 lines
        vsync = 1'b0;
        step();
        exp_addr = 0;
        check("err_cleared_line", 32'(line_err), 0);
        check("err_cleared_ovf", 32'(ovf_err), 0);
        for (int l = 0; l <= V; l++) send_line(l * H + 5, 1);
        check("ovf_err_set", 32'(ovf_err), 1);
        check("ovf_addr_hold", 32'(pixel_addr), TOTAL - 1);
        check("ovf_line_err", 32'(line_err), 0);
        vsync = 1'b1;
        step();
        step();

        // capture_en dropped during a frame
        vsync = 1'b0;
        step();
        exp_addr = 0;
        send_line(3, 1);
        capture_en = 1'b0;
        vsync = 1'b1;
        step();
        check("cen0_frame_done", 32'(frame_done), 1);
        step();
        check("cen0_idle", 32'(busy), 0);
        start_frame();
        send_line(0, 0);
        send_line(8, 0);
        check("cen0_still_idle", 32'(busy), 0);
        vsync = 1'b1;
        step();
        step();
        check("frame_done_count", 32'(fd_cnt), 4);

        // Reset mid-line
        capture_en = 1'b1;
        start_frame();
        send_line(0, 1);
        send_line(8, 1);
        for (int i = 0; i < 3; i++) send_pair(8'(i), 8'(i + 1), 1);
        send_byte(8'h55);
        reset = 1'b1;
        step();
        check("mid_rst_pixel_out", 32'(pixel_out), 0);
        check("mid_rst_valid", 32'(pixel_valid), 0);
        check("mid_rst_addr", 32'(pixel_addr), 0);
        check("mid_rst_line_err", 32'(line_err), 0);
        check("mid_rst_ovf_err", 32'(ovf_err), 0);
        check("mid_rst_busy", 32'(busy), 0);
        reset = 1'b0;
        send_line(0, 0);
        check("post_rst_idle", 32'(busy), 0);
        start_frame();
        send_pair(8'h12, 8'h34, 1);
        check("restart_addr0", 32'(pixel_addr), 0);
        check("restart_pix0", 32'(pixel_out), 32'h1234);
        for (int i = 1; i < H; i++) send_pair(8'(i), 8'(i), 1);
        gap();

        for (int n = 0; n < 20 && exp_q.size() != 0; n++) step();
        check("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
